alu_cmd_sequencer: RTL and testbench
====================================

Name: alu_cmd_sequencer

Overview:
Initiator side of the arithmetic unit interface. It takes command frames from a byte stream (the UART RX path), drives operands, `alu_fun` and a one-cycle `arith_enable` into the arithmetic unit, and captures `arith_out`/`carry_out` when `arith_flag` rises. It then serializes the result as bytes toward the TX FIFO over a valid/ready handshake.

Parameters:
- OPER_WIDTH, 16, operand width driven to arithmetic unit; must be 16 (two bytes per operand).
- RES_WIDTH, 32, width of `arith_out`; must be 32 (four result bytes).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rx_data  in  8  command byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  sequencer accepts byte this cycle
- alu_a  out  OPER_WIDTH  operand A to arithmetic unit
- alu_b  out  OPER_WIDTH  operand B to arithmetic unit
- alu_fun  out  4  operation select
- arith_enable  out  1  one-cycle execute strobe
- arith_out  in  RES_WIDTH  registered arithmetic result
- arith_flag  in  1  result valid (high the cycle after enable)
- carry_out  in  1  result carry/borrow bit
- tx_data  out  8  result byte
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  downstream accepts byte
- busy  out  1  high in any state other than IDLE
- frame_err  out  1  one-cycle pulse on a rejected header byte

Behaviour:
- Reset (sync, rst=1 at posedge clk): state=IDLE; rx_ready=1; `alu_a`, `alu_b`, `alu_fun`, arith_enable, tx_data, tx_valid, busy and frame_err all = 0. Reset overrides everything, including mid-frame or mid-transmit. A partial frame is dropped and no further tx bytes are sent.
- Byte transfer occurs only when rx_valid and rx_ready are both high at posedge.
- Frame format: header, A_lo, A_hi, B_lo, B_hi.
  - Header [7:4] must equal 4'hA; header [3:0] is latched into `alu_fun`.
  - Operands are little-endian.
- FSM states: IDLE, GET_A0, GET_A1, GET_B0, GET_B1, EXEC, WAIT, SEND.
  - IDLE: on an accepted byte with [7:4]==4'hA, latch `alu_fun` and go to GET_A0. On any other accepted byte, pulse frame_err for 1 cycle and stay in IDLE.
  - GET_A0 / GET_A1 / GET_B0 / GET_B1: each accepted byte fills the corresponding operand byte; advance to the next state.
  - EXEC: one cycle with arith_enable=1; `alu_a`, `alu_b` and `alu_fun` are stable from this cycle until WAIT exits.
  - Divide by zero: if `alu_fun`[1:0]==2'b11 and alu_b==0, EXEC does NOT assert arith_enable. The result register is loaded with 32'hFFFF_FFFF, carry=1, and the FSM goes directly to SEND.
  - WAIT: when arith_flag=1, capture arith_out and carry_out, then go to SEND. Required latency: arith_flag appears the cycle after EXEC.
  - SEND: tx_valid=1. tx_data emits the result bytes LSB first (byte0..byte3). A byte index advances only on tx_valid && tx_ready. tx_data is held stable while tx_ready=0. After the last byte is accepted, go to IDLE.
- rx_ready=1 only in IDLE and GET_* states; 0 in EXEC, WAIT and SEND. No byte is consumed during processing.
- busy=1 in every state except IDLE.
- Throughput: header accept to first tx_valid is 7 cycles with continuous rx_valid and no stalls.
- Operands and the result register hold their last values in IDLE. Outputs change only at the transitions listed above.

Optional Feature:
- Macro: ALU_STATUS_BYTE_EN.
- Defined: SEND emits a 5th byte after byte3 = {6'b0, div_by_zero, captured carry_out}.
- Undefined: exactly 4 result bytes are sent; carry is captured but not transmitted.

Test Plan:
- ADD: frame A0 34 12 01 00 -> one-cycle arith_enable with alu_a=0x1234, alu_b=0x0001; tx bytes 35 12 00 00.
- MUL with backpressure: frame A2 FF FF FF FF, tx_ready low for 3 cycles per byte -> tx bytes 01 00 FE FF; tx_data stable while stalled; no duplicated or lost bytes.
- SUB underflow: frame A1 01 00 02 00 -> tx bytes FF FF FF FF; with ALU_STATUS_BYTE_EN the 5th byte is 0x01.
- Divide by zero: frame A3 10 00 00 00 -> no arith_enable pulse; tx bytes FF FF FF FF; with ALU_STATUS_BYTE_EN the 5th byte is 0x03.
- Bad header: byte 0x53 then a valid ADD frame -> one frame_err pulse, 0x53 ignored, valid frame processed normally.
- Reset mid-frame: A0 34, then rst high 1 cycle, then frame A0 02 00 03 00 -> all outputs zero after reset; tx bytes 05 00 00 00 only.

Source files
------------

// File: rtl/alu_cmd_sequencer_if.sv
// -----------------------------------------------------------------------------
// alu_cmd_sequencer_if
//
// Purpose : Bundles every non-clock/reset signal of the command sequencer so
//           the sequencer and its environment connect through one port.
//
// Signals :
//   rx_data[7:0]   command byte from the UART RX path
//   rx_valid       rx_data valid
//   rx_ready       sequencer accepts a byte this cycle
//   alu_a/alu_b    operands to the arithmetic unit (OPER_WIDTH)
//   alu_fun[3:0]   operation select
//   arith_enable   one-cycle execute strobe
//   arith_out      registered arithmetic result (RES_WIDTH)
//   arith_flag     result valid, the cycle after arith_enable
//   carry_out      result carry/borrow
//   tx_data[7:0]   result byte toward the TX FIFO
//   tx_valid       tx_data valid
//   tx_ready       downstream accepts a byte
//   busy           sequencer is not idle
//   frame_err      one-cycle pulse on a rejected header byte
//
// Modports:
//   master - the sequencer itself
//   slave  - the environment (byte source, arithmetic unit, TX sink)
// -----------------------------------------------------------------------------
interface alu_cmd_sequencer_if #(
   parameter int OPER_WIDTH = 16,
   parameter int RES_WIDTH  = 32
);

   logic [7:0]            rx_data;
   logic                  rx_valid;
   logic                  rx_ready;
   logic [OPER_WIDTH-1:0] alu_a;
   logic [OPER_WIDTH-1:0] alu_b;
   logic [3:0]            alu_fun;
   logic                  arith_enable;
   logic [RES_WIDTH-1:0]  arith_out;
   logic                  arith_flag;
   logic                  carry_out;
   logic [7:0]            tx_data;
   logic                  tx_valid;
   logic                  tx_ready;
   logic                  busy;
   logic                  frame_err;

   modport master (
      input  rx_data, rx_valid,
      output rx_ready,
      output alu_a, alu_b, alu_fun, arith_enable,
      input  arith_out, arith_flag, carry_out,
      output tx_data, tx_valid,
      input  tx_ready,
      output busy, frame_err
   );

   modport slave (
      output rx_data, rx_valid,
      input  rx_ready,
      input  alu_a, alu_b, alu_fun, arith_enable,
      output arith_out, arith_flag, carry_out,
      input  tx_data, tx_valid,
      output tx_ready,
      input  busy, frame_err
   );

endinterface

// File: rtl/alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// alu_cmd_sequencer
//
// Purpose : Initiator side of the arithmetic unit. Collects a 5-byte command
//           frame (header, A_lo, A_hi, B_lo, B_hi) from a byte stream, fires a
//           one-cycle arith_enable, captures the result on arith_flag, and
//           streams the 32-bit result out LSB first over valid/ready.
//           Divide by zero (alu_fun[1:0]==3, B==0) skips the arithmetic unit
//           and returns 32'hFFFF_FFFF with carry set.
//
// Ports   :
//   clk   system clock
//   rst   synchronous, active-high reset
//   bus   alu_cmd_sequencer_if.master (rx byte stream, arithmetic unit
//         interface, tx byte stream, busy, frame_err)
//
// Options :
//   ALU_STATUS_BYTE_EN  when defined, a 5th byte {6'b0, div_by_zero, carry}
//                       follows the four result bytes.
// -----------------------------------------------------------------------------
module alu_cmd_sequencer #(
   parameter int OPER_WIDTH = 16,  // two bytes per operand
   parameter int RES_WIDTH  = 32   // four result bytes
) (
   input  logic                clk,
   input  logic                rst,
   alu_cmd_sequencer_if.master bus
);

   typedef enum logic [2:0] {
      IDLE,
      GET_A0,
      GET_A1,
      GET_B0,
      GET_B1,
      EXEC,
      WAIT,
      SEND
   } state_t;

   localparam logic [3:0] HDR_TAG = 4'hA;

`ifdef ALU_STATUS_BYTE_EN
   localparam logic [2:0] LAST_IDX = 3'd4;
`else
   localparam logic [2:0] LAST_IDX = 3'd3;
`endif

   state_t                state_q,     state_d;
   logic [OPER_WIDTH-1:0] alu_a_q,     alu_a_d;
   logic [OPER_WIDTH-1:0] alu_b_q,     alu_b_d;
   logic [3:0]            alu_fun_q,   alu_fun_d;
   logic [RES_WIDTH-1:0]  result_q,    result_d;
   logic                  carry_q,     carry_d;
   logic                  div0_q,      div0_d;
   logic [2:0]            idx_q,       idx_d;
   logic                  frame_err_q, frame_err_d;

   logic       rx_ready_c;
   logic       rx_fire;
   logic       arith_enable_c;
   logic [7:0] tx_byte;

   assign rx_ready_c = (state_q inside {IDLE, GET_A0, GET_A1, GET_B0, GET_B1});
   assign rx_fire    = bus.rx_valid && rx_ready_c;

   // -------------------------------------------------------------------------
   // Next-state and datapath load logic
   // -------------------------------------------------------------------------
   always_comb begin
      // NOTE: every target gets its hold value first, so no path through the
      // case statement can leave a signal unassigned and infer a latch.
      state_d        = state_q;
      alu_a_d        = alu_a_q;
      alu_b_d        = alu_b_q;
      alu_fun_d      = alu_fun_q;
      result_d       = result_q;
      carry_d        = carry_q;
      div0_d         = div0_q;
      idx_d          = idx_q;
      frame_err_d    = 1'b0;
      arith_enable_c = 1'b0;

      case (state_q)
         IDLE: begin
            if (rx_fire) begin
               if (bus.rx_data[7:4] == HDR_TAG) begin
                  alu_fun_d = bus.rx_data[3:0];
                  state_d   = GET_A0;
               end else begin
                  frame_err_d = 1'b1;
               end
            end
         end
         GET_A0: begin
            if (rx_fire) begin
               alu_a_d[7:0] = bus.rx_data;
               state_d      = GET_A1;
            end
         end
         GET_A1: begin
            if (rx_fire) begin
               alu_a_d[15:8] = bus.rx_data;
               state_d       = GET_B0;
            end
         end
         GET_B0: begin
            if (rx_fire) begin
               alu_b_d[7:0] = bus.rx_data;
               state_d      = GET_B1;
            end
         end
         GET_B1: begin
            if (rx_fire) begin
               alu_b_d[15:8] = bus.rx_data;
               state_d       = EXEC;
            end
         end
         EXEC: begin
            idx_d = 3'd0;
            if ((alu_fun_q[1:0] == 2'b11) && (alu_b_q == '0)) begin
               // Divide by zero never reaches the arithmetic unit.
               result_d = '1;
               carry_d  = 1'b1;
               div0_d   = 1'b1;
               state_d  = SEND;
            end else begin
               arith_enable_c = 1'b1;
               div0_d         = 1'b0;
               state_d        = WAIT;
            end
         end
         WAIT: begin
            if (bus.arith_flag) begin
               result_d = bus.arith_out;
               carry_d  = bus.carry_out;
               state_d  = SEND;
            end
         end
         SEND: begin
            if (bus.tx_ready) begin
               if (idx_q == LAST_IDX) begin
                  idx_d   = 3'd0;
                  state_d = IDLE;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // State and datapath registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      if (rst) begin
         state_q     <= IDLE;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_fun_q   <= '0;
         result_q    <= '0;
         carry_q     <= 1'b0;
         div0_q      <= 1'b0;
         idx_q       <= 3'd0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_fun_q   <= alu_fun_d;
         result_q    <= result_d;
         carry_q     <= carry_d;
         div0_q      <= div0_d;
         idx_q       <= idx_d;
         frame_err_q <= frame_err_d;
      end
   end

   // -------------------------------------------------------------------------
   // Result byte select. Index 4 (status) is only reachable when the status
   // byte is enabled; keeping it in the mux in both builds is harmless.
   // -------------------------------------------------------------------------
   always_comb begin
      case (idx_q)
         3'd0:    tx_byte = result_q[7:0];
         3'd1:    tx_byte = result_q[15:8];
         3'd2:    tx_byte = result_q[23:16];
         3'd3:    tx_byte = result_q[31:24];
         default: tx_byte = {6'b0, div0_q, carry_q};
      endcase
   end

   // -------------------------------------------------------------------------
   // Outputs: all decoded from registered state, so they only move on edges.
   // -------------------------------------------------------------------------
   assign bus.rx_ready     = rx_ready_c;
   assign bus.alu_a        = alu_a_q;
   assign bus.alu_b        = alu_b_q;
   assign bus.alu_fun      = alu_fun_q;
   assign bus.arith_enable = arith_enable_c;
   assign bus.tx_valid     = (state_q == SEND);
   assign bus.tx_data      = (state_q == SEND) ? tx_byte : 8'h00;
   assign bus.busy         = (state_q != IDLE);
   assign bus.frame_err    = frame_err_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_cmd_sequencer
//
// Directed frames with hand-computed results. Each frame pushes its expected
// arithmetic-unit call and result bytes into queues; independent monitors pop
// and compare when the DUT strobes arith_enable or transfers a tx byte.
// A small registered arithmetic-unit model answers arith_enable one cycle
// later with arith_flag.
// -----------------------------------------------------------------------------
module tb_alu_cmd_sequencer;

   logic clk;
   logic rst;

   alu_cmd_sequencer_if #(.OPER_WIDTH(16), .RES_WIDTH(32)) bus ();

   alu_cmd_sequencer #(.OPER_WIDTH(16), .RES_WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic [3:0]  fun;
   } en_t;

   en_t        en_q[$];
   logic [7:0] tx_q[$];

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int fe_count = 0;
   int hdr_cyc = 0;
   int lat_exp_g = 0;
   bit lat_armed = 1'b0;
   int stall_n = 0;

   // ---------------------------------------------------------------- helpers
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail(input string name, input string msg);
      n_cmp++;
      n_err++;
      $display("FAIL %s: %s (cycle %0d)", name, msg, cyc);
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // ------------------------------------------------ arithmetic unit model
   logic        en_s = 1'b0;
   logic [15:0] a_s, b_s;
   logic [3:0]  fun_s;

   initial forever begin
      @(negedge clk);
      en_s  = (bus.arith_enable === 1'b1);
      a_s   = bus.alu_a;
      b_s   = bus.alu_b;
      fun_s = bus.alu_fun;
      if (en_s) begin
         if (en_q.size() == 0) begin
            fail("arith_enable", "unexpected execute strobe");
         end else begin
            en_t e;
            e = en_q.pop_front();
            check("alu_a", {16'h0, a_s}, {16'h0, e.a});
            check("alu_b", {16'h0, b_s}, {16'h0, e.b});
            check("alu_fun", {28'h0, fun_s}, {28'h0, e.fun});
         end
      end
   end

   initial begin
      bus.arith_flag = 1'b0;
      bus.arith_out  = '0;
      bus.carry_out  = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         bus.arith_flag = en_s;
         if (en_s) begin
            case (fun_s[1:0])
               2'd0: begin
                  bus.arith_out = {16'h0, a_s} + {16'h0, b_s};
                  bus.carry_out = bus.arith_out[16];
               end
               2'd1: begin
                  bus.arith_out = {16'h0, a_s} - {16'h0, b_s};
                  bus.carry_out = (a_s < b_s);
               end
               2'd2: begin
                  bus.arith_out = {16'h0, a_s} * {16'h0, b_s};
                  bus.carry_out = 1'b0;
               end
               default: begin
                  bus.arith_out = (b_s != 0) ? {16'h0, a_s / b_s} : 32'h0;
                  bus.carry_out = 1'b0;
               end
            endcase
         end
      end
   end

   // ------------------------------------------------------ tx_ready driver
   initial begin
      int cnt;
      cnt = 0;
      bus.tx_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (stall_n == 0) begin
            bus.tx_ready = 1'b1;
            cnt = 0;
         end else if (cnt == stall_n) begin
            bus.tx_ready = 1'b1;
            cnt = 0;
         end else begin
            bus.tx_ready = 1'b0;
            cnt++;
         end
      end
   end

   // ------------------------------------------------------------ tx monitor
   initial begin
      bit         prev_stall;
      logic [7:0] prev_data;
      logic [7:0] exp_b;
      prev_stall = 1'b0;
      prev_data  = 8'h00;
      forever begin
         @(negedge clk);
         if (bus.frame_err === 1'b1) fe_count++;
         if (bus.tx_valid === 1'b1) begin
            if (lat_armed) begin
               check("latency", cyc - hdr_cyc, lat_exp_g);
               lat_armed = 1'b0;
            end
            if (prev_stall) check("tx_hold", {24'h0, bus.tx_data}, {24'h0, prev_data});
            if (bus.tx_ready) begin
               if (tx_q.size() == 0) begin
                  fail("tx_extra", $sformatf("unexpected byte %h", bus.tx_data));
               end else begin
                  exp_b = tx_q.pop_front();
                  check("tx_byte", {24'h0, bus.tx_data}, {24'h0, exp_b});
               end
               prev_stall = 1'b0;
            end else begin
               prev_stall = 1'b1;
               prev_data  = bus.tx_data;
            end
         end else begin
            if (prev_stall) fail("tx_valid_drop", "tx_valid fell while stalled");
            prev_stall = 1'b0;
         end
      end
   end

   // ---------------------------------------------------------- stimulus
   task automatic send_byte(input logic [7:0] b, output int acc_cyc);
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      acc_cyc = -1;
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         if (bus.rx_ready === 1'b1) begin
            acc_cyc = cyc;
            break;
         end
      end
      if (acc_cyc < 0) fail("rx_accept", "byte not accepted within 50 cycles");
      @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] h, input logic [7:0] a0, input logic [7:0] a1,
                             input logic [7:0] b0, input logic [7:0] b1, input int lat_exp);
      int c;
      send_byte(h, c);
      hdr_cyc   = c;
      lat_exp_g = lat_exp;
      lat_armed = 1'b1;
      send_byte(a0, c);
      send_byte(a1, c);
      send_byte(b0, c);
      send_byte(b1, c);
      bus.rx_valid = 1'b0;
   endtask

   task automatic expect_exec(input logic [15:0] a, input logic [15:0] b, input logic [3:0] fun);
      en_t e;
      e.a = a;
      e.b = b;
      e.fun = fun;
      en_q.push_back(e);
   endtask

   task automatic expect_result(input logic [31:0] r, input logic [7:0] status);
      tx_q.push_back(r[7:0]);
      tx_q.push_back(r[15:8]);
      tx_q.push_back(r[23:16]);
      tx_q.push_back(r[31:24]);
`ifdef ALU_STATUS_BYTE_EN
      tx_q.push_back(status);
`else
      if (status == 8'hEE) $display("unused status %h", status);
`endif
   endtask

   task automatic wait_done();
      bit done;
      done = 1'b0;
      for (int t = 0; t < 400; t++) begin
         @(negedge clk);
         if (bus.busy === 1'b0 && bus.tx_valid === 1'b0 && tx_q.size() == 0) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) fail("wait_done", "frame did not complete within 400 cycles");
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_rx_ready"},     {31'h0, bus.rx_ready},     32'h1);
      check({tag, "_busy"},         {31'h0, bus.busy},         32'h0);
      check({tag, "_alu_a"},        {16'h0, bus.alu_a},        32'h0);
      check({tag, "_alu_b"},        {16'h0, bus.alu_b},        32'h0);
      check({tag, "_alu_fun"},      {28'h0, bus.alu_fun},      32'h0);
      check({tag, "_arith_enable"}, {31'h0, bus.arith_enable}, 32'h0);
      check({tag, "_tx_valid"},     {31'h0, bus.tx_valid},     32'h0);
      check({tag, "_tx_data"},      {24'h0, bus.tx_data},      32'h0);
      check({tag, "_frame_err"},    {31'h0, bus.frame_err},    32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int c;
      rst          = 1'b1;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      check_idle_outputs("reset");
      rst = 1'b0;
      @(posedge clk);
      #1;

      // ADD: 0x1234 + 0x0001
      expect_exec(16'h1234, 16'h0001, 4'h0);
      expect_result(32'h0000_1235, 8'h00);
      send_frame(8'hA0, 8'h34, 8'h12, 8'h01, 8'h00, 7);
      wait_done();

      // MUL with tx backpressure: 0xFFFF * 0xFFFF
      stall_n = 3;
      expect_exec(16'hFFFF, 16'hFFFF, 4'h2);
      expect_result(32'hFFFE_0001, 8'h00);
      send_frame(8'hA2, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 7);
      wait_done();
      stall_n = 0;

      // SUB underflow: 1 - 2, borrow set
      expect_exec(16'h0001, 16'h0002, 4'h1);
      expect_result(32'hFFFF_FFFF, 8'h01);
      send_frame(8'hA1, 8'h01, 8'h00, 8'h02, 8'h00, 7);
      wait_done();

      // Divide by zero: no execute strobe, straight to SEND
      expect_result(32'hFFFF_FFFF, 8'h03);
      send_frame(8'hA3, 8'h10, 8'h00, 8'h00, 8'h00, 6);
      wait_done();

      // Bad header 0x53, then a normal ADD
      send_byte(8'h53, c);
      bus.rx_valid = 1'b0;
      check("bad_hdr_busy", {31'h0, bus.busy}, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      check("bad_hdr_fe_count", fe_count, 1);
      expect_exec(16'h1234, 16'h0001, 4'h0);
      expect_result(32'h0000_1235, 8'h00);
      send_frame(8'hA0, 8'h34, 8'h12, 8'h01, 8'h00, 7);
      wait_done();

      // ADD with carry out of 16 bits
      expect_exec(16'hFFFF, 16'h0001, 4'h0);
      expect_result(32'h0001_0000, 8'h01);
      send_frame(8'hA0, 8'hFF, 8'hFF, 8'h01, 8'h00, 7);
      wait_done();

      // DIV with non-zero divisor: 100 / 7
      expect_exec(16'h0064, 16'h0007, 4'h3);
      expect_result(32'h0000_000E, 8'h00);
      send_frame(8'hA3, 8'h64, 8'h00, 8'h07, 8'h00, 7);
      wait_done();

      // Reset mid-frame drops the partial frame
      send_byte(8'hA0, c);
      send_byte(8'h34, c);
      bus.rx_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_idle_outputs("rst_mid");
      rst = 1'b0;
      expect_exec(16'h0002, 16'h0003, 4'h0);
      expect_result(32'h0000_0005, 8'h00);
      send_frame(8'hA0, 8'h02, 8'h00, 8'h03, 8'h00, 7);
      wait_done();

      repeat (10) @(posedge clk);
      #1;
      check("tx_q_drained", tx_q.size(), 0);
      check("en_q_drained", en_q.size(), 0);
      check("frame_err_total", fe_count, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
